axi_reg_initiator: RTL and testbench

AXI4-Lite initiator that turns a simple command/response interface into single-beat register reads and writes toward an AXI register slave. It forms AxADDR from a fixed base address and a word offset, which mirrors how the slave decodes tag, offset and byte bits. It sits between local control logic (sequencers, test harnesses, CPU-less bring-up) and the register fabric, and has exactly one transaction outstanding at a time.

---
 rtl/axi_reg_pkg.sv | 7 +
 rtl/axi_addr_encoder.sv | 10 +
 rtl/axi_reg_initiator.sv | 179 +++++++++++++++++
 tb/tb_axi_reg_initiator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/axi_reg_pkg.sv
// axi_reg_pkg: shared response codes, FSM states and bus widths for axi_reg_initiator.
package axi_reg_pkg;
  localparam int DataWidth = 32;
  localparam int StrbWidth = 4;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_e;
endpackage

// File: rtl/axi_addr_encoder.sv
// axi_addr_encoder: builds an aligned in-window address from the base tag and a word offset.
module axi_addr_encoder #(
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int OffsetWidth = 6
) (
  input  logic [OffsetWidth-1:0] offset,
  output logic [31:0]            addr
);
  assign addr = {BaseAddr[31:OffsetWidth+2], offset, 2'b00};
endmodule

// File: rtl/axi_reg_initiator.sv
// axi_reg_initiator: command/response to single-beat AXI4-Lite reads and writes, one outstanding.
// Optional B/R wait limit and sticky timed_out flag with AXI_REG_INITIATOR_TIMEOUT_EN.
module axi_reg_initiator import axi_reg_pkg::*; #(
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int OffsetWidth = 6
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
  , parameter int TimeoutCycles = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [OffsetWidth-1:0] cmd_offset,
  input  logic [DataWidth-1:0]   cmd_wdata,
  input  logic [StrbWidth-1:0]   cmd_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DataWidth-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            awaddr,
  output logic [2:0]             awprot,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [DataWidth-1:0]   wdata,
  output logic [StrbWidth-1:0]   wstrb,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [31:0]            araddr,
  output logic [2:0]             arprot,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [DataWidth-1:0]   rdata,
  input  logic [1:0]             rresp
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
  , output logic                 timed_out
`endif
);
  state_e state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic [31:0] addr_q, addr_d, enc_addr;
  logic [DataWidth-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [StrbWidth-1:0] wstrb_q, wstrb_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic timed_out_q, timed_out_d;
  assign timed_out = timed_out_q;
`endif
  axi_addr_encoder #(.BaseAddr(BaseAddr), .OffsetWidth(OffsetWidth)) u_enc (
    .offset(cmd_offset),
    .addr  (enc_addr)
  );
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign arvalid   = arvalid_q;
  assign bready    = bready_q;
  assign rready    = rready_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  // Each valid/ready holds until its own handshake; a late B/R after a timeout drains the same way.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awvalid_d   = awvalid_q & ~awready;
    wvalid_d    = wvalid_q & ~wready;
    arvalid_d   = arvalid_q & ~arready;
    bready_d    = bready_q & ~bvalid;
    rready_d    = rready_q & ~rvalid;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
    timed_out_d = timed_out_q;
    cnt_d       = (state_q == WR_RESP || state_q == RD_DATA) ? cnt_q + 32'd1 : '0;
`endif
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        state_d   = cmd_write ? WR_ADDR : RD_ADDR;
        addr_d    = enc_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        awvalid_d = cmd_write;
        wvalid_d  = cmd_write;
        arvalid_d = !cmd_write;
      end
      WR_ADDR: if (!awvalid_d && !wvalid_d) begin
        state_d  = WR_RESP;
        bready_d = 1'b1;
      end
      WR_RESP: if (bvalid) begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_resp_d  = bresp;
        rsp_rdata_d = '0;
      end
      RD_ADDR: if (arready) begin
        state_d  = RD_DATA;
        rready_d = 1'b1;
      end
      RD_DATA: if (rvalid) begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_resp_d  = rresp;
        rsp_rdata_d = rdata;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
    if (((state_q == WR_RESP && !bvalid) || (state_q == RD_DATA && !rvalid)) &&
        cnt_q == 32'(TimeoutCycles - 1)) begin
      state_d     = RSP;
      rsp_valid_d = 1'b1;
      rsp_resp_d  = SLVERR;
      rsp_rdata_d = '0;
      timed_out_d = 1'b1;
    end
`endif
    cmd_ready_d = state_d == IDLE && !bready_d && !rready_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi_reg_initiator.sv
// tb_axi_reg_initiator: directed vectors for axi_reg_initiator; inputs driven and outputs sampled on negedge.
module tb_axi_reg_initiator;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [5:0] cmd_offset = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready;
  logic [31:0] awaddr, araddr, wdata, rdata = '0;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp = '0, rresp = '0;
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
  logic timed_out;
`endif
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  axi_reg_initiator #(
    .BaseAddr(32'h4000_0000),
    .OffsetWidth(6)
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
    , .TimeoutCycles(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
    , .timed_out(timed_out)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  // Returns at the negedge of cycle 1 (one cycle after acceptance).
  task automatic issue(input logic wr, input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_write = wr; cmd_offset = off; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_valid = 0;
  endtask
  task automatic run_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input logic [31:0] exp_addr);
    awready = 1; wready = 1;
    issue(1, off, d, s);
    check("wr_awvalid", {31'd0, awvalid}, 32'd1);
    check("wr_wvalid", {31'd0, wvalid}, 32'd1);
    check("wr_awaddr", awaddr, exp_addr);
    check("wr_wdata", wdata, d);
    check("wr_wstrb", {28'd0, wstrb}, {28'd0, s});
    check("wr_awprot", {29'd0, awprot}, 32'd0);
    check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    check("wr_bready", {31'd0, bready}, 32'd1);
    check("wr_aw_drop", {31'd0, awvalid}, 32'd0);
    check("wr_rsp_early", {31'd0, rsp_valid}, 32'd0);
    bvalid = 1; bresp = resp;
    step();
    bvalid = 0;
    check("wr_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_resp", {30'd0, rsp_resp}, {30'd0, resp});
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_bready_drop", {31'd0, bready}, 32'd0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("wr_rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask
  initial begin
    step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, bready | rready}, 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
    check("rst_timed_out", {31'd0, timed_out}, 32'd0);
`endif
    rst = 0;
    step();
    run_write(6'd5, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h4000_0014);
    // Read at the top offset with SLVERR, then hold rsp_ready low five cycles.
    arready = 1;
    issue(0, 6'd63, 32'h0, 4'h0);
    check("rd_arvalid", {31'd0, arvalid}, 32'd1);
    check("rd_araddr", araddr, 32'h4000_00FC);
    check("rd_wvalid", {31'd0, wvalid | awvalid}, 32'd0);
    step();
    check("rd_rready", {31'd0, rready}, 32'd1);
    check("rd_ar_drop", {31'd0, arvalid}, 32'd0);
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
    step();
    rvalid = 0; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("rd_hold_rdata", rsp_rdata, 32'h1234_5678);
      check("rd_hold_resp", {30'd0, rsp_resp}, 32'd2);
      check("rd_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      step();
    end
    check("rd_still_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("rd_rsp_done", {31'd0, rsp_valid}, 32'd0);
    check("rd_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    // awready delayed three cycles, wready immediate.
    awready = 0; wready = 1;
    issue(1, 6'd1, 32'hA5A5_5A5A, 4'h3);
    check("bp_aw_c1", {30'd0, awvalid, wvalid}, 32'd3);
    step();
    check("bp_aw_c2", {30'd0, awvalid, wvalid}, 32'd2);
    step();
    check("bp_aw_c3", {30'd0, awvalid, wvalid}, 32'd2);
    step();
    check("bp_aw_c4", {30'd0, awvalid, wvalid}, 32'd2);
    check("bp_bready_early", {31'd0, bready}, 32'd0);
    check("bp_awaddr_stable", awaddr, 32'h4000_0004);
    awready = 1;
    step();
    check("bp_aw_c5", {31'd0, awvalid}, 32'd0);
    check("bp_bready", {31'd0, bready}, 32'd1);
    bvalid = 1; bresp = 2'b01;
    step();
    bvalid = 0;
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_rsp_resp", {30'd0, rsp_resp}, 32'd1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("bp_rsp_done", {31'd0, rsp_valid}, 32'd0);
    // Reset while waiting for R.
    arready = 1;
    issue(0, 6'd2, 32'h0, 4'h0);
    step();
    check("rr_rready_pre", {31'd0, rready}, 32'd1);
    rst = 1;
    #1;
    check("rr_drop", {29'd0, arvalid, rready, rsp_valid}, 32'd0);
    check("rr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    rst = 0;
    run_write(6'd10, 32'h0BAD_F00D, 4'h5, 2'b00, 32'h4000_0028);
`ifdef AXI_REG_INITIATOR_TIMEOUT_EN
    // No B arrives: SLVERR after eight cycles, then a late B is drained.
    awready = 1; wready = 1;
    issue(1, 6'd3, 32'h1111_2222, 4'hF);
    step();
    for (int i = 0; i < 7; i++) begin
      check("to_wait", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    check("to_wait_last", {31'd0, rsp_valid}, 32'd0);
    step();
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_resp", {30'd0, rsp_resp}, 32'd2);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    check("to_flag", {31'd0, timed_out}, 32'd1);
    check("to_bready_held", {31'd0, bready}, 32'd1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("to_drain_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    bvalid = 1;
    step();
    bvalid = 0;
    check("to_drained_bready", {31'd0, bready}, 32'd0);
    check("to_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("to_flag_sticky", {31'd0, timed_out}, 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
